scroll_msg_buffer: RTL and testbench
====================================

# scroll_msg_buffer

Message source for the 3-digit multiplexed seven-segment driver. Holds a writable ASCII message of up to DEPTH characters and advances a 3-character window across it at a programmable rate. Each visible character is encoded to a segment pattern, and the three patterns are presented to the downstream digit-scan stage as registered, tear-free outputs.

## Interface
- DEPTH, 16: message buffer entries; power of two, at most 16.
- TICK_DIV, 5_000_000: clk cycles per scroll step; must be at least 8.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write wr_char to buffer[wr_addr].
- wr_addr  in  4  buffer index; bits above log2(DEPTH) are ignored.
- wr_char  in  8  ASCII character.
- len_wr  in  1  load message length from len.
- len  in  5  message length; values above DEPTH clamp to DEPTH.
- run  in  1  scrolling enabled.
- seg_d0  out  8  leftmost digit pattern; bit7=dp, bit6..0=g..a, active-high.
- seg_d1  out  8  middle digit pattern.
- seg_d2  out  8  rightmost digit pattern.
- upd  out  1  one-cycle pulse when seg_d0..d2 change.

## Operation
- Registers: L (message length, 0..DEPTH), p (window pointer, 0..L-1), tick counter, FSM, pending flag.
- The buffer is single-read-port and has no reset. The displayed character for digit k is buffer[(p+k) mod L], so L=1 or L=2 repeats characters across digits.
- If L=0, all segment outputs show 0x00.
- Tick counter:
  - Counts while run=1.
  - At TICK_DIV-1 it wraps to 0 and produces step.
  - run=0 clears the counter to 0.
- On step with L>0: p <= (p+1) mod L, and a refresh is requested.
- On len_wr: L <= min(len, DEPTH), p <= 0, tick counter <= 0, and a refresh is requested.
- If len_wr and step occur in the same cycle, len_wr wins and p=0.
- Any wr_en requests a refresh; the buffer write completes that cycle.
- FSM states:
  - IDLE: waits for a refresh request or the pending flag.
  - F0, F1, F2: read characters p, p+1, p+2 (mod L) into holding registers, one per cycle.
  - COMMIT: encode all three, load seg_d0..d2 together, pulse upd, then return to IDLE.
- A refresh request during F0..COMMIT sets the pending flag. IDLE consumes the flag and starts F0 on the next cycle. No request is lost, and multiple requests merge into one.
- A refresh with L=0 still runs the FSM; COMMIT writes 0x00 to all digits.
- Encoding (lowercase letters map like uppercase):
  - Digits '0'..'9': 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Letters: A 77, B 7C, C 39, D 5E, E 79, F 71, H 76, L 38, P 73, S 6D, U 3E.
  - Symbols: space 00, '-' 40, '.' 80.
  - Any other character: 00.

## Timing
- Reset values:
  - seg_d0..d2 = 0x00, upd = 0.
  - L = 0, p = 0, tick = 0, FSM = IDLE, pending = 0.
- Refresh latency: the request is registered at edge N, F0 starts at N+1, and COMMIT happens at edge N+4. Outputs and upd are valid after edge N+4, and upd is high for exactly one cycle.
- Outputs never change outside COMMIT, so there is no partial-window tearing.
- With run held at 1, a step fires every TICK_DIV cycles, the first one TICK_DIV cycles after run rises.
- Reset asserted mid-fetch aborts the fetch immediately: outputs return to 0x00 and upd is never asserted.
- p wrap: with p = L-1, a step sets p = 0.
- Writing a character that is currently displayed updates the digit 4 cycles later, without any step.

## Test plan
- Reset, then write "SEP" to addr 0..2 and set len=3 with run=0: exactly one upd pulse, then seg_d0/d1/d2 = 6D/79/73.
- With TICK_DIV=8 and run=1: every 8 cycles the window rotates to 79/73/6D, then 73/6D/79, then back to 6D/79/73, with one upd per step.
- Set len=1 with buffer[0]='8': all digits show 7F. Set len=0: all digits show 00.
- Write 'x' then 'a' to addr 0 on consecutive cycles during F1: the final outputs show 77 on digit 0, and at most two upd pulses occur in total.
- Assert len_wr (len=20) and step in the same cycle: L=16, p=0, and the window starts at buffer[0].
- Assert rst during F2 of a pending refresh: outputs stay 00, no upd occurs, and after release a len_wr restores normal operation.

Source files
------------

// File: rtl/scroll_msg_buffer_if.sv
// Control and display bundle for scroll_msg_buffer.
// master = message writer / display consumer, slave = the buffer.
interface scroll_msg_buffer_if;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_char;
   logic       len_wr;
   logic [4:0] len;
   logic       run;
   logic [7:0] seg_d0;
   logic [7:0] seg_d1;
   logic [7:0] seg_d2;
   logic       upd;

   modport master (
      output wr_en, wr_addr, wr_char,
      output len_wr, len, run,
      input  seg_d0, seg_d1, seg_d2, upd
   );

   modport slave (
      input  wr_en, wr_addr, wr_char,
      input  len_wr, len, run,
      output seg_d0, seg_d1, seg_d2, upd
   );
endinterface

// File: rtl/scroll_msg_buffer.sv
// Scrolling 3-character window over a writable ASCII message,
// fetched one char per cycle and committed to seg outputs at once.
module scroll_msg_buffer #(
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 5_000_000
) (
   input  logic              clk,
   input  logic              rst,
   scroll_msg_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [4:0]    DEPTH_L  = 5'(DEPTH);
   localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_F0,
      S_F1,
      S_F2,
      S_COMMIT
   } state_t;

   logic [7:0]    r_buf [DEPTH];
   logic [4:0]    r_len;
   logic [3:0]    r_ptr;
   logic [TW-1:0] r_tick;
   state_t        r_state;
   logic          r_pend;
   logic [7:0]    r_h0;
   logic [7:0]    r_h1;
   logic [7:0]    r_h2;
   logic [7:0]    r_seg0;
   logic [7:0]    r_seg1;
   logic [7:0]    r_seg2;
   logic          r_upd;

   logic          w_step;
   logic          w_req;
   logic          w_len_nz;
   logic [4:0]    w_len_clamp;
   logic [4:0]    w_ptr_p1;
   logic [1:0]    w_k;
   logic [4:0]    w_sum;
   logic [AW-1:0] w_raddr;
   logic [7:0]    w_rdata;
   logic          w_unused;

   function automatic logic [7:0] f_enc(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      case (u)
         8'h30:   return 8'h3F;
         8'h31:   return 8'h06;
         8'h32:   return 8'h5B;
         8'h33:   return 8'h4F;
         8'h34:   return 8'h66;
         8'h35:   return 8'h6D;
         8'h36:   return 8'h7D;
         8'h37:   return 8'h07;
         8'h38:   return 8'h7F;
         8'h39:   return 8'h6F;
         8'h41:   return 8'h77;
         8'h42:   return 8'h7C;
         8'h43:   return 8'h39;
         8'h44:   return 8'h5E;
         8'h45:   return 8'h79;
         8'h46:   return 8'h71;
         8'h48:   return 8'h76;
         8'h4C:   return 8'h38;
         8'h50:   return 8'h73;
         8'h53:   return 8'h6D;
         8'h55:   return 8'h3E;
         8'h2D:   return 8'h40;
         8'h2E:   return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   assign w_len_nz    = |r_len;
   assign w_len_clamp = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
   assign w_step      = bus.run && (r_tick == TICK_MAX);
   assign w_req       = bus.wr_en | bus.len_wr | (w_step & w_len_nz);
   assign w_ptr_p1    = {1'b0, r_ptr} + 5'd1;

   // (p+k) mod L; two subtractions cover L=1 where p+2 can reach 2L
   always_comb begin
      unique case (r_state)
         S_F1:    w_k = 2'd1;
         S_F2:    w_k = 2'd2;
         default: w_k = 2'd0;
      endcase
      w_sum = {1'b0, r_ptr} + {3'b000, w_k};
      if (w_sum >= r_len) w_sum = w_sum - r_len;
      if (w_sum >= r_len) w_sum = w_sum - r_len;
   end

   assign w_raddr  = w_sum[AW-1:0];
   assign w_rdata  = r_buf[w_raddr];
   assign w_unused = w_sum[4];

   always_ff @(posedge clk) begin
      if (bus.wr_en)
         r_buf[bus.wr_addr[AW-1:0]] <= bus.wr_char;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len  <= '0;
         r_ptr  <= '0;
         r_tick <= '0;
      end else if (bus.len_wr) begin
         r_len  <= w_len_clamp;
         r_ptr  <= '0;
         r_tick <= '0;
      end else begin
         if (!bus.run)
            r_tick <= '0;
         else if (w_step)
            r_tick <= '0;
         else
            r_tick <= r_tick + 1'b1;
         if (w_step && w_len_nz)
            r_ptr <= (w_ptr_p1 == r_len) ? 4'd0 : w_ptr_p1[3:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pend  <= 1'b0;
         r_h0    <= 8'h00;
         r_h1    <= 8'h00;
         r_h2    <= 8'h00;
         r_seg0  <= 8'h00;
         r_seg1  <= 8'h00;
         r_seg2  <= 8'h00;
         r_upd   <= 1'b0;
      end else begin
         r_upd <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_req || r_pend) begin
                  r_state <= S_F0;
                  r_pend  <= 1'b0;
               end
            end
            S_F0: begin
               r_h0    <= w_rdata;
               r_state <= S_F1;
            end
            S_F1: begin
               r_h1    <= w_rdata;
               r_state <= S_F2;
            end
            S_F2: begin
               r_h2    <= w_rdata;
               r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               r_seg0  <= w_len_nz ? f_enc(r_h0) : 8'h00;
               r_seg1  <= w_len_nz ? f_enc(r_h1) : 8'h00;
               r_seg2  <= w_len_nz ? f_enc(r_h2) : 8'h00;
               r_upd   <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         // requests landing mid-fetch re-run the whole window afterwards
         if (r_state != S_IDLE && w_req)
            r_pend <= 1'b1;
      end
   end

   assign bus.seg_d0 = r_seg0;
   assign bus.seg_d1 = r_seg1;
   assign bus.seg_d2 = r_seg2;
   assign bus.upd    = r_upd;
endmodule

// File: tb/tb_scroll_msg_buffer.sv
// Randomized and directed bench for scroll_msg_buffer with a
// message/window reference model computed from the display rules.
module tb_scroll_msg_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scroll_msg_buffer_if bus ();

   scroll_msg_buffer #(
      .DEPTH    (16),
      .TICK_DIV (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int upd_cnt = 0;
   int upd_cyc = -1;

   logic [7:0] m_buf [16];
   int m_len = 0;
   int m_p   = 0;

   logic [7:0] dig_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
   string      letters = "ABCDEFHLPSU";
   logic [7:0] let_seg [11] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
                                8'h76, 8'h38, 8'h73, 8'h6D, 8'h3E};
   string      pool = "0123456789abcdefhlpsuABCDEFHLPSU -.?xz";

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.upd === 1'b1) begin
         upd_cnt = upd_cnt + 1;
         upd_cyc = cyc;
      end
   end

   function automatic logic [7:0] m_enc(input logic [7:0] c);
      logic [7:0] u = c;
      if (c >= 8'h61 && c <= 8'h7A) u = c - 8'h20;
      if (u >= 8'h30 && u <= 8'h39) return dig_tab[u - 8'h30];
      for (int i = 0; i < 11; i++)
         if (u == letters[i]) return let_seg[i];
      if (u == 8'h2D) return 8'h40;
      if (u == 8'h2E) return 8'h80;
      return 8'h00;
   endfunction

   function automatic logic [7:0] m_win(input int k);
      if (m_len == 0) return 8'h00;
      return m_enc(m_buf[(m_p + k) % m_len]);
   endfunction

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int a, input logic [7:0] c);
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'(a);
      bus.wr_char = c;
      clk_n(1);
      bus.wr_en = 1'b0;
      m_buf[a % 16] = c;
   endtask

   task automatic set_len(input int l);
      bus.len_wr = 1'b1;
      bus.len    = 5'(l);
      clk_n(1);
      bus.len_wr = 1'b0;
      m_len = (l > 16) ? 16 : l;
      m_p   = 0;
   endtask

   function automatic logic [7:0] rnd_char();
      if ($urandom_range(0, 1) == 0)
         return pool[$urandom_range(0, pool.len() - 1)];
      return 8'($urandom);
   endfunction

   task automatic test_reset();
      logic [7:0] obs [3];
      clk_n(3);
      total++;
      if (bus.upd !== 1'b0) begin
         bad++;
         $display("FAIL reset_upd got %b want 0", bus.upd);
      end
      rst = 1'b0;
      clk_n(2);
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== 8'h00) begin
            bad++;
            $display("FAIL reset_d%0d got %02h want 00", k, obs[k]);
         end
      end
   endtask

   task automatic test_sep();
      logic [7:0] obs [3];
      int n0, e;
      wr(0, "S");
      wr(1, "E");
      wr(2, "P");
      clk_n(12);
      n0 = upd_cnt;
      e  = cyc + 1;
      set_len(3);
      clk_n(15);
      total++;
      if (upd_cnt - n0 !== 1) begin
         bad++;
         $display("FAIL sep_upd_count got %0d want 1", upd_cnt - n0);
      end
      total++;
      if (upd_cyc !== e + 4) begin
         bad++;
         $display("FAIL sep_latency got %0d want %0d", upd_cyc, e + 4);
      end
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL sep_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
   endtask

   task automatic test_scroll();
      logic [7:0] obs [3];
      int r0, n0, t;
      r0 = cyc;
      bus.run = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         n0 = upd_cnt;
         t  = 0;
         while (upd_cnt == n0 && t < 20) begin
            clk_n(1);
            t++;
         end
         m_p = (m_p + 1) % m_len;
         total++;
         if (upd_cyc !== r0 + 8 * i + 4) begin
            bad++;
            $display("FAIL scroll_step%0d_time got %0d want %0d",
                     i, upd_cyc, r0 + 8 * i + 4);
         end
         obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== m_win(k)) begin
               bad++;
               $display("FAIL scroll_step%0d_d%0d got %02h want %02h",
                        i, k, obs[k], m_win(k));
            end
         end
      end
      bus.run = 1'b0;
      clk_n(12);
   endtask

   task automatic test_len_edges();
      logic [7:0] obs [3];
      wr(0, "8");
      set_len(1);
      clk_n(12);
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL len1_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
      set_len(0);
      clk_n(12);
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL len0_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
   endtask

   task automatic test_write_during_fetch();
      logic [7:0] obs [3];
      int n0, d;
      wr(1, "E");
      wr(2, "P");
      clk_n(12);
      n0 = upd_cnt;
      set_len(3);
      clk_n(1);
      wr(0, "x");
      wr(0, "a");
      clk_n(16);
      d = upd_cnt - n0;
      total++;
      if (d > 2 || d < 1) begin
         bad++;
         $display("FAIL wfetch_upd_count got %0d want 1..2", d);
      end
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL wfetch_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
   endtask

   task automatic test_len_step_collision();
      logic [7:0] obs [3];
      int r0, n0;
      for (int a = 0; a < 16; a++) wr(a, pool[$urandom_range(0, pool.len() - 1)]);
      clk_n(12);
      set_len(3);
      clk_n(12);
      r0 = cyc;
      bus.run = 1'b1;
      clk_n(7);
      n0 = upd_cnt;
      set_len(20);
      clk_n(5);
      total++;
      if (upd_cnt - n0 !== 1 || upd_cyc !== r0 + 12) begin
         bad++;
         $display("FAIL coll_commit got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                  upd_cnt - n0, upd_cyc, r0 + 12);
      end
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL coll_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
      clk_n(8);
      m_p = 1;
      total++;
      if (upd_cyc !== r0 + 20) begin
         bad++;
         $display("FAIL coll_next_step got %0d want %0d", upd_cyc, r0 + 20);
      end
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL coll_p1_d%0d got %02h want %02h", k, obs[k], m_win(k));
         end
      end
      bus.run = 1'b0;
      clk_n(12);
   endtask

   task automatic test_reset_mid_fetch();
      logic [7:0] obs [3];
      int n0;
      set_len(3);
      wr(1, "u");
      clk_n(1);
      n0 = upd_cnt;
      #2;
      rst = 1'b1;
      #1;
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_d%0d got %02h want 00", k, obs[k]);
         end
      end
      clk_n(2);
      rst = 1'b0;
      m_len = 0;
      m_p   = 0;
      clk_n(20);
      total++;
      if (upd_cnt !== n0) begin
         bad++;
         $display("FAIL rstmid_no_upd got %0d want 0", upd_cnt - n0);
      end
      set_len(3);
      clk_n(12);
      obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs[k] !== m_win(k)) begin
            bad++;
            $display("FAIL rstmid_resume_d%0d got %02h want %02h",
                     k, obs[k], m_win(k));
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] obs [3];
      int m;
      for (int it = 0; it < 10; it++) begin
         repeat ($urandom_range(1, 6)) wr($urandom_range(0, 15), rnd_char());
         set_len($urandom_range(0, 20));
         repeat ($urandom_range(0, 3)) wr($urandom_range(0, 15), rnd_char());
         clk_n(12);
         m = $urandom_range(0, 40);
         bus.run = 1'b1;
         clk_n(m);
         bus.run = 1'b0;
         if (m_len > 0) m_p = (m / 8) % m_len;
         clk_n(12);
         obs = '{bus.seg_d0, bus.seg_d1, bus.seg_d2};
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs[k] !== m_win(k)) begin
               bad++;
               $display("FAIL rand%0d_d%0d len=%0d steps=%0d got %02h want %02h",
                        it, k, m_len, m / 8, obs[k], m_win(k));
            end
         end
      end
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.wr_addr = 4'd0;
      bus.wr_char = 8'h00;
      bus.len_wr  = 1'b0;
      bus.len     = 5'd0;
      bus.run     = 1'b0;
      test_reset();
      test_sep();
      test_scroll();
      test_len_edges();
      test_write_during_fetch();
      test_len_step_collision();
      test_reset_mid_fetch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
